toggle_tally: RTL



---
 rtl/toggle_tally.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/toggle_tally.sv
// rtl/toggle_tally.sv - per-bit rise/fall toggle counters with a valid/ready readout stream
module toggle_tally #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16,
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1,
    localparam int COV_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] sample_i,
    input  logic             clear,
    input  logic             rd_req,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [IDX_W-1:0] rd_idx,
    output logic [CNT_W-1:0] rd_rise,
    output logic [CNT_W-1:0] rd_fall,
    output logic             rd_last,
    output logic             busy,
    output logic [COV_W-1:0] covered_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_PRESENT
    } state_t;

    logic [CNT_W-1:0] rise_q [WIDTH];
    logic [CNT_W-1:0] rise_d [WIDTH];
    logic [CNT_W-1:0] fall_q [WIDTH];
    logic [CNT_W-1:0] fall_d [WIDTH];
    logic [WIDTH-1:0] prev_q, prev_d;
    logic             base_vld_q, base_vld_d;
    logic [COV_W-1:0] cov_q, cov_d;
    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] rd_rise_q, rd_rise_d;
    logic [CNT_W-1:0] rd_fall_q, rd_fall_d;

    // Sampling and counting; the first enabled sample only establishes the baseline.
    always_comb begin
        rise_d     = rise_q;
        fall_d     = fall_q;
        prev_d     = prev_q;
        base_vld_d = base_vld_q;
        if (clear) begin
            for (int i = 0; i < WIDTH; i++) begin
                rise_d[i] = '0;
                fall_d[i] = '0;
            end
            base_vld_d = 1'b0;
        end else if (enable) begin
            prev_d     = sample_i;
            base_vld_d = 1'b1;
            if (base_vld_q) begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (!prev_q[i] && sample_i[i] && rise_q[i] != CNT_MAX) begin
                        rise_d[i] = rise_q[i] + 1'b1;
                    end
                    if (prev_q[i] && !sample_i[i] && fall_q[i] != CNT_MAX) begin
                        fall_d[i] = fall_q[i] + 1'b1;
                    end
                end
            end
        end
    end

    // Coverage popcount looks at the registered counters, hence one cycle behind them.
    always_comb begin
        cov_d = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (rise_q[i] != '0 && fall_q[i] != '0) begin
                cov_d = cov_d + COV_W'(1);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        rd_rise_d = rd_rise_q;
        rd_fall_d = rd_fall_q;
        if (clear) begin
            state_d   = S_IDLE;
            idx_d     = '0;
            rd_rise_d = '0;
            rd_fall_d = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (rd_req) begin
                        state_d = S_LOAD;
                        idx_d   = '0;
                    end
                end
                S_LOAD: begin
                    rd_rise_d = rise_q[idx_q];
                    rd_fall_d = fall_q[idx_q];
                    state_d   = S_PRESENT;
                end
                S_PRESENT: begin
                    if (rd_ready) begin
                        if (idx_q == LAST_IDX) begin
                            state_d = S_IDLE;
                        end else begin
                            idx_d   = idx_q + 1'b1;
                            state_d = S_LOAD;
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                rise_q[i] <= '0;
                fall_q[i] <= '0;
            end
            prev_q     <= '0;
            base_vld_q <= 1'b0;
            cov_q      <= '0;
            state_q    <= S_IDLE;
            idx_q      <= '0;
            rd_rise_q  <= '0;
            rd_fall_q  <= '0;
        end else begin
            rise_q     <= rise_d;
            fall_q     <= fall_d;
            prev_q     <= prev_d;
            base_vld_q <= base_vld_d;
            cov_q      <= cov_d;
            state_q    <= state_d;
            idx_q      <= idx_d;
            rd_rise_q  <= rd_rise_d;
            rd_fall_q  <= rd_fall_d;
        end
    end

    assign rd_valid    = (state_q == S_PRESENT);
    assign busy        = (state_q != S_IDLE);
    assign rd_idx      = idx_q;
    assign rd_rise     = rd_rise_q;
    assign rd_fall     = rd_fall_q;
    assign rd_last     = (state_q == S_PRESENT) && (idx_q == LAST_IDX);
    assign covered_cnt = cov_q;

endmodule
